// File: rtl/req_encoder_4_2.sv
// req_encoder_4_2: captures request pulses into a pending register and
// presents one pending index at a time as a registered code with valid/ack.
//
// Parameters:
//   RR_MODE    0 = fixed priority (d[3] highest), 1 = round-robin
//   CLR_ON_ACK 1 = ack clears the granted pending bit, 0 = ack ignored
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   en    in   capture enable for d (does not gate ack)
//   d     in   [3:0] request pulses, bit i = request for index i
//   e     out  [1:0] registered index of the granted request
//   valid out  e holds a pending index
//   ack   in   consumer accepted e (effective only when valid=1)
//   pend  out  [3:0] pending request register
//   ovf   out  sticky: a request hit an already-pending index

module req_encoder_4_2 #(
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned CLR_ON_ACK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] d,
    output logic [1:0] e,
    output logic       valid,
    input  logic       ack,
    output logic [3:0] pend,
    output logic       ovf
);

    logic [3:0] pend_q, pend_d;
    logic [1:0] e_q, e_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic [1:0] ptr_q, ptr_d;

    logic       take;
    logic [3:0] clr;
    logic [3:0] set;
    logic [1:0] sel;

    // Index of the highest set bit; v is known non-zero when used.
    function automatic logic [1:0] pick_hi(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[3])      r = 2'd3;
        else if (v[2]) r = 2'd2;
        else if (v[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

    // First set bit scanning start, start+1, ... modulo 4.
    // Rotate right by start, take the lowest set bit, then add start back.
    function automatic logic [1:0] pick_rr(input logic [3:0] v,
                                           input logic [1:0] start);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] off;
        dbl = {v, v};
        rot = dbl[start +: 4];
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else             off = 2'd3;
        return start + off;
    endfunction

    always_comb begin
        take    = 1'b0;
        clr     = 4'b0000;
        set     = 4'b0000;
        sel     = 2'd0;
        pend_d  = pend_q;
        e_d     = e_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;

        take = valid_q & ack & (CLR_ON_ACK != 0);
        if (take) begin
            clr = 4'b0001 << e_q;
        end
        if (en) begin
            set = d;
        end

        // Set wins over clear on the same bit, so a re-request of the
        // index being acked simply stays pending without flagging ovf.
        pend_d = (pend_q & ~clr) | set;
        ovf_d  = ovf_q | (|(set & pend_q & ~clr));

        if (take) begin
            ptr_d = e_q + 2'd1;
        end

        // Round-robin scans from the updated pointer so the index just
        // serviced is the last candidate at the same edge.
        if (RR_MODE != 0) begin
            sel = pick_rr(pend_d, ptr_d);
        end else begin
            sel = pick_hi(pend_d);
        end

        valid_d = |pend_d;
        if (valid_d) begin
            e_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 4'b0000;
            e_q     <= 2'b00;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ptr_q   <= 2'b00;
        end else begin
            pend_q  <= pend_d;
            e_q     <= e_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign pend  = pend_q;
    assign e     = e_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/req_encoder_4_2.md
Name: req_encoder_4_2

Overview:
- Sequential 4-to-2 encoder. It is the inverse of the team's 2x4 decoder.
- Captures one-hot or multi-hot request pulses on a 4-bit line into a pending register.
- Presents the index of the selected pending request as a registered 2-bit code, with a valid/ack handshake.
- Sits between interrupt/event sources and a consumer that services one index at a time.

Parameters:
RR_MODE, 0, selection policy: 0 = fixed priority (d[3] highest, d[0] lowest); 1 = round-robin
CLR_ON_ACK, 1, 1 = ack clears the granted pending bit; 0 = ack is ignored and pending clears only via reset (debug use)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  capture enable for d; does not gate ack
d  input  4  request pulses, bit i = request for index i
e  output  2  encoded index of the granted request (registered)
valid  output  1  e holds a pending index (registered)
ack  input  1  consumer accepted e; effective only when valid=1
pend  output  4  pending request register (status)
ovf  output  1  sticky: a request arrived on an already-pending index

Behaviour:
- Reset (rst=1 at a rising edge):
  - pend=4'b0000, e=2'b00, valid=0, ovf=0, round-robin pointer ptr=2'b00.
  - Reset takes priority over all other inputs.
  - Reset mid-handshake discards all pending requests; an ack in the same cycle has no effect.
- Handshake and clear:
  - take = valid & ack & CLR_ON_ACK.
  - clr = 4'b0001 << e when take=1, else 4'b0000.
  - ack while valid=0 is ignored.
- Capture: set = en ? d : 4'b0000.
- Pending update every edge: pend_n = (pend & ~clr) | set.
  - Set wins over clear on the same bit: that bit is re-pended with no ovf.
- Overflow:
  - ovf sets when en=1 and (d & pend & ~clr) != 0.
  - Once set, ovf holds until rst.
  - The request is not lost, since that bit is already pending.
- Selection on pend_n, registered into e/valid at the same edge:
  - valid_n = |pend_n.
  - Fixed priority: e_n = index of the highest set bit of pend_n.
  - Round-robin: e_n = first set bit of pend_n scanning ptr, ptr+1, ... modulo 4.
  - When take=1, ptr <= e+1 mod 4, so 3 wraps to 0. Otherwise ptr holds.
  - When valid_n=0, e holds its previous value.
- Latency: request on d sampled at edge k gives valid=1 and the matching e after edge k, i.e. one cycle.
- Back-to-back: ack at edge k with other bits pending gives the next index presented after edge k. Each index can be serviced in one cycle.
- e and valid change only at clock edges. No combinational path from d or ack to e or valid.
- While valid=1 and ack=0, e may change if a higher-priority request arrives (fixed mode).
  - Consumers must sample e and ack in the same cycle.
- en=0: d is ignored and no ovf is raised. Pending bits still drain via ack.
- Expected implementation size: 120-250 lines.

Test Plan:
- Reset: assert rst for 2 cycles with d=4'b1111, en=1 -> pend=0000, valid=0, e=00, ovf=0 throughout the reset cycles.
- Fixed priority, RR_MODE=0:
  - Pulse d=4'b0110 for one cycle -> next cycle valid=1, e=10, pend=0110.
  - ack 1 cycle -> e=01.
  - ack -> valid=0, pend=0000.
- Round-robin, RR_MODE=1:
  - Hold pend=1111 by pulsing d=1111 once, then ack every cycle -> e sequence 00,01,10,11, then valid=0.
  - Repeat with ptr=3 -> first grant 11, then wraps to 00.
- Set/clear collision: valid=1 with e=10; drive ack=1 and d=4'b0100 in the same cycle -> pend[2] stays 1, valid=1, e=10, ovf=0.
- Overflow and enable:
  - d=0001 pulse, then d=0001 again with ack=0 -> ovf=1 and stays 1 after pend drains.
  - With en=0, d=1000 -> pend unchanged, no ovf change.
- Reset mid-operation: pend=1010, valid=1; assert rst with ack=1 -> next cycle pend=0000, valid=0, ptr=00, ovf=0.
